// File: rtl/lcompressor_pkg.sv
// Shared definitions for the lcompressor arbiter slice: default sizes and the
// {vld, chan} tag that travels alongside each sample through the compressor.
package lcompressor_pkg;

  localparam int unsigned LCMP_DW      = 8;
  localparam int unsigned LCMP_NCH     = 4;
  localparam int unsigned LCMP_LATENCY = 1;

  // Wide enough for the largest supported channel count (8).
  localparam int unsigned LCMP_CHAN_W  = 3;

  typedef struct packed {
    logic                   vld;
    logic [LCMP_CHAN_W-1:0] chan;
  } lcmp_tag_t;

endpackage

// File: rtl/lcompressor_rr_arb.sv
// Pointer-based round-robin grant logic. The channel after the most recently
// granted one has top priority; the pointer only moves on a real handshake.
module lcompressor_rr_arb
  import lcompressor_pkg::*;
#(
  parameter int unsigned NCH = LCMP_NCH,
  localparam int unsigned CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           en,
  input  logic           hs,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx
);

  logic [CW-1:0] last_q;
  logic          found;
  int unsigned   cand;
  logic [CW-1:0] cidx;

  // Search last+1, last+2, ... (mod NCH) for the first requesting channel.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NCH) cand = cand - NCH;
      cidx = cand[CW-1:0];
      if (!found && req[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
    gnt = '0;
    if (en && found) gnt[idx] = 1'b1;
  end

  // Pointer register; reset to NCH-1 so channel 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= CW'(NCH - 1);
    end else if (hs) begin
      last_q <= idx;
    end
  end

endmodule

// File: rtl/lcompressor_arb.sv
// Round-robin front end that time-shares one lcompressor between NCH sources.
// Each accepted sample carries a channel tag through a pipeline matched to the
// compressor latency so the result comes back labelled with its source.
// Optional macro LCOMPRESSOR_ARB_STATS_EN adds per-channel saturating grant
// counters on o_grant_cnt.
module lcompressor_arb
  import lcompressor_pkg::*;
#(
  parameter int unsigned NCH     = LCMP_NCH,
  parameter int unsigned DW      = LCMP_DW,
  parameter int unsigned LATENCY = LCMP_LATENCY,
  localparam int unsigned CW     = $clog2(NCH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NCH-1:0]    i_valid,
  input  logic [NCH*DW-1:0] i_data,
  output logic [NCH-1:0]    o_ready,
  output logic [DW-1:0]     o_cmp_data,
  input  logic [DW-1:0]     i_cmp_data,
  output logic              o_valid,
  output logic [DW-1:0]     o_data,
  output logic [CW-1:0]     o_chan,
`ifdef LCOMPRESSOR_ARB_STATS_EN
  output logic [NCH*16-1:0] o_grant_cnt,
`endif
  output logic              o_busy
);

  logic [NCH-1:0]          gnt;
  logic [CW-1:0]           gnt_idx;
  logic                    hs;
  logic [DW-1:0]           sample;
  lcmp_tag_t               tag_in;
  lcmp_tag_t [LATENCY:0]   tag_q;
  logic [DW-1:0]           cmp_q;
  logic                    valid_q;
  logic [DW-1:0]           data_q;
  logic [CW-1:0]           chan_q;
  logic                    busy;
  logic                    unused_chan;

  lcompressor_rr_arb #(
    .NCH (NCH)
  ) u_rr_arb (
    .clk   (i_clk),
    .reset (i_reset),
    .req   (i_valid),
    .en    (i_en & ~i_reset),
    .hs    (hs),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );

  assign o_ready = gnt;
  assign hs      = |(i_valid & gnt);
  assign sample  = i_data[32'(gnt_idx) * DW +: DW];

  // Tag entering stage 0; idle cycles inject an empty tag.
  always_comb begin
    tag_in     = '0;
    tag_in.vld = hs;
    if (hs) tag_in.chan = LCMP_CHAN_W'(gnt_idx);
  end

  // Issue register, tag shift register and output stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cmp_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      cmp_q   <= hs ? sample : '0;
      tag_q   <= {tag_q[LATENCY-1:0], tag_in};
      valid_q <= tag_q[LATENCY].vld;
      // Data and tag hold between results.
      if (tag_q[LATENCY].vld) begin
        data_q <= i_cmp_data;
        chan_q <= tag_q[LATENCY].chan[CW-1:0];
      end
    end
  end

  // Busy while any tag is in the pipe or a result is being presented.
  always_comb begin
    busy = valid_q;
    for (int unsigned j = 0; j <= LATENCY; j++) begin
      busy = busy | tag_q[j].vld;
    end
  end

  assign unused_chan = ^tag_q[LATENCY].chan;

  assign o_cmp_data = cmp_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_chan     = chan_q;
  assign o_busy     = busy;

`ifdef LCOMPRESSOR_ARB_STATS_EN
  logic [NCH-1:0][15:0] cnt_q;

  // Per-channel handshake counters, saturating at 0xFFFF.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (i_valid[k] && gnt[k] && (cnt_q[k] != 16'hFFFF)) begin
          cnt_q[k] <= cnt_q[k] + 16'd1;
        end
      end
    end
  end

  assign o_grant_cnt = cnt_q;
`endif

endmodule

// File: doc/lcompressor_arb.md
# lcompressor_arb

Round-robin arbiter that time-shares one `lcompressor` datapath between `NCH` sample requesters. It accepts one sample per cycle from the granted requester and drives it into the compressor. It tags the sample with its channel index through a latency-matched pipeline and returns the compressed result with that tag. It sits between the per-channel sample sources and the single compressor instance.

## Interface
Parameters:
- `NCH`, 4, number of requesters (2..8)
- `DW`, 8, sample width; must match the compressor data width
- `LATENCY`, 1, compressor input-to-output latency in cycles (1..4)

Ports:
- `i_clk` in 1: clock. One clock domain.
- `i_reset` in 1: reset. Synchronous, active-high.
- `i_en` in 1: grant enable. Low means no new grants.
- `i_valid` in NCH: per-channel request.
- `i_data` in NCH*DW: per-channel sample. Channel k occupies `[k*DW +: DW]`.
- `o_ready` out NCH: one-hot-or-zero grant (combinational).
- `o_cmp_data` out DW: sample driven to the compressor.
- `i_cmp_data` in DW: compressor output.
- `o_valid` out 1: result valid, single-cycle pulse per result.
- `o_data` out DW: compressed result.
- `o_chan` out $clog2(NCH): channel tag of `o_data`.
- `o_busy` out 1: any sample in flight.
- `o_grant_cnt` out NCH*16: per-channel grant counters. Present only with the stats macro.

## Operation
- Handshake on channel k: `i_valid[k] & o_ready[k]` at a rising edge.
- `o_ready` is zero when `i_en=0` or `i_reset=1`.
- Arbitration:
  - `last` pointer holds the most recently granted channel.
  - Search order is `last+1`, `last+2`, … modulo NCH. The first channel with `i_valid` high is granted.
  - `last` updates only on a handshake.
  - Reset value of `last` is NCH-1, so channel 0 wins first.
- Issue stage, at the handshake edge:
  - `o_cmp_data` ← granted sample.
  - Tag pipeline stage 0 ← {1, k}.
  - With no handshake: `o_cmp_data` ← 0 and stage 0 ← {0, x}.
- Tag pipeline:
  - LATENCY+1 stages of {vld, chan}, shifting every cycle unconditionally.
  - The final stage aligns with `i_cmp_data`.
- Output stage, registered:
  - `o_valid` ← final-stage vld.
  - `o_data` ← `i_cmp_data`.
  - `o_chan` ← final-stage chan.
  - `o_data` and `o_chan` hold when `o_valid=0`.
- There is no output backpressure. Consumers must accept every `o_valid` pulse.
- `o_busy` = OR of all tag-stage vld bits and `o_valid`.
- `i_en` falling: in-flight samples complete normally. Only new grants stop.
- A requester dropping `i_valid` without a handshake loses nothing. Arbitration is re-evaluated each cycle.
- Reset values: `o_cmp_data`=0, `o_valid`=0, `o_data`=0, `o_chan`=0, all tag vld=0, `last`=NCH-1, counters=0.
- Reset mid-operation:
  - All in-flight tags are cleared.
  - No `o_valid` is produced for samples issued before reset.
  - The first grant after reset release goes to channel 0.

## Timing
- Handshake at edge t produces:
  - `o_cmp_data` valid after edge t.
  - `i_cmp_data` valid after edge t+LATENCY.
  - `o_valid`/`o_data`/`o_chan` valid after edge t+LATENCY+1.
- Throughput: one sample per cycle aggregate.
- With all NCH channels continuously valid, each channel is granted exactly once every NCH cycles.
- Result order equals grant order.
- A single active channel is granted every cycle.

## Configuration
- `LCOMPRESSOR_ARB_STATS_EN` defined:
  - Per-channel 16-bit grant counters on `o_grant_cnt`.
  - Each counter increments on that channel's handshake and saturates at 0xFFFF.
  - Counters clear on `i_reset`.
- Not defined:
  - Port `o_grant_cnt` and all counter logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `lcompressor_pkg` holds:
  - `LCMP_DW` (8), `LCMP_NCH` (4), `LCMP_LATENCY` (1) defaults.
  - Tag typedef {vld, chan}.
- Sub-module `lcompressor_rr_arb` contains the pointer-based round-robin grant logic. Inputs: request vector, enable, handshake. Outputs: one-hot grant and index.
- The tag pipeline and output stage live in the top level.

## Test plan
- Only ch2 valid, `i_data[ch2]`=0x40 held for 3 cycles → `o_ready`=4'b0100 each cycle. Three `o_valid` pulses with `o_chan`=2 starting LATENCY+1 edges after the first handshake; `o_data` equals the compressor output for 0x40.
- All four valid continuously after reset → grant order 0,1,2,3,0,1…; `o_chan` sequence identical, delayed by LATENCY+1.
- ch1 and ch3 valid, `last`=1 → ch3 granted, then ch1, alternating.
- `i_reset` pulsed one cycle with 2 samples in flight → no `o_valid` for them; `o_busy`=0 the cycle after reset; first post-reset grant goes to ch0.
- `i_en`=0 with all channels valid → `o_ready`=0. Earlier in-flight results still emerge. `o_busy` falls after the last `o_valid`.
- With `LCOMPRESSOR_ARB_STATS_EN`: 65540 grants to ch0 → `o_grant_cnt[ch0]`=0xFFFF; other counters unchanged.
